// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
//   uart_rx_state_t : receiver FSM states
//   PT_*            : parity-type string constants accepted by the PT parameter
//   parity_calc     : parity bit a transmitter would send for the given data
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_t;

    localparam string PT_NONE = "NONE";
    localparam string PT_EVEN = "EVEN";
    localparam string PT_ODD  = "ODD";

    // data is zero-extended by the caller; odd selects odd parity
    function automatic logic parity_calc(input logic [31:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning for the serial line.
//   clk  : system clock
//   rst  : asynchronous reset, active-high (all flops reset to the idle level 1)
//   rxd  : raw asynchronous serial input
//   rxs  : synchronized (and optionally filtered) serial line
// Optional feature macro: UART_RX_FILTER_EN adds a 3-tap majority vote after
// the synchronizer (2 extra cycles of latency, single-cycle glitches rejected).
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rxs
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end

`ifdef UART_RX_FILTER_EN
    logic [2:0] tap_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_q <= 3'b111;
        end else begin
            tap_q <= {tap_q[1:0], sync_q[1]};
        end
    end

    assign rxs = (tap_q[0] & tap_q[1]) | (tap_q[0] & tap_q[2]) | (tap_q[1] & tap_q[2]);
`else
    assign rxs = sync_q[1];
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: deserializes uart_rxd into a valid/ready byte stream.
//   clk, rst        : clock, asynchronous active-high reset
//   uart_rxd        : serial input, idle high
//   str_rxd_tvalid  : received byte valid (held until accepted)
//   str_rxd_tdata   : received byte
//   str_rxd_tready  : consumer accepts the byte
//   error_fifo      : 1-cycle pulse, new byte dropped because output still held
//   error_parity    : 1-cycle pulse with the delivered byte, parity mismatch
//   error_frame     : 1-cycle pulse, a stop bit sampled low (byte dropped)
// Optional feature macro: UART_RX_FILTER_EN (see uart_rx_sync).
module uart_rx import uart_pkg::*; #(
    parameter int unsigned DW = 8,
    parameter string       PT = "NONE",
    parameter int unsigned SW = 1,
    parameter int unsigned BN = 54
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          uart_rxd,
    output logic          str_rxd_tvalid,
    output logic [DW-1:0] str_rxd_tdata,
    input  logic          str_rxd_tready,
    output logic          error_fifo,
    output logic          error_parity,
    output logic          error_frame
);

    localparam int unsigned CW = $clog2(BN);
    localparam int unsigned IW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] HalfLoad = CW'(BN / 2 - 1);
    localparam logic [CW-1:0] BitLoad  = CW'(BN - 1);
    localparam bit ParEn  = (PT != PT_NONE);
    localparam bit ParOdd = (PT == PT_ODD);

    logic rxs;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .rxd (uart_rxd),
        .rxs (rxs)
    );

    uart_rx_state_t state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [DW-1:0]  shreg_q, shreg_d;
    logic           par_err_q, par_err_d;
    logic           frame_q, frame_d;
    logic           stop_idx_q, stop_idx_d;
    logic           seen_high_q, seen_high_d;
    logic           tvalid_q, tvalid_d;
    logic [DW-1:0]  tdata_q, tdata_d;
    logic           err_fifo_q, err_fifo_d;
    logic           err_par_q, err_par_d;
    logic           err_frame_q, err_frame_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            par_err_q   <= 1'b0;
            frame_q     <= 1'b0;
            stop_idx_q  <= 1'b0;
            seen_high_q <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            err_fifo_q  <= 1'b0;
            err_par_q   <= 1'b0;
            err_frame_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            par_err_q   <= par_err_d;
            frame_q     <= frame_d;
            stop_idx_q  <= stop_idx_d;
            seen_high_q <= seen_high_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            err_fifo_q  <= err_fifo_d;
            err_par_q   <= err_par_d;
            err_frame_q <= err_frame_d;
        end
    end

    always_comb begin
        logic expired;
        logic complete;
        logic frame_now;

        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        par_err_d   = par_err_q;
        frame_d     = frame_q;
        stop_idx_d  = stop_idx_q;
        seen_high_d = seen_high_q;
        tvalid_d    = tvalid_q;
        tdata_d     = tdata_q;
        err_fifo_d  = 1'b0;
        err_par_d   = 1'b0;
        err_frame_d = 1'b0;
        complete    = 1'b0;
        frame_now   = frame_q;

        // Counter loaded with N expires N+1 clocks later, when it reads zero.
        expired = (cnt_q == '0);
        if (!expired) begin
            cnt_d = cnt_q - 1'b1;
        end

        // A break leaves the line low; require a high level before re-arming.
        if (state_q == IDLE && rxs) begin
            seen_high_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!rxs && seen_high_q) begin
                    state_d     = START;
                    cnt_d       = HalfLoad;
                    seen_high_d = 1'b0;
                end
            end
            START: begin
                if (expired) begin
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        cnt_d     = BitLoad;
                        idx_d     = '0;
                        par_err_d = 1'b0;
                        frame_d   = 1'b0;
                    end
                end
            end
            DATA: begin
                if (expired) begin
                    shreg_d[idx_q] = rxs;
                    cnt_d          = BitLoad;
                    if (idx_q == IW'(DW - 1)) begin
                        state_d    = ParEn ? PARITY : STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (expired) begin
                    par_err_d  = parity_calc(32'(shreg_q), ParOdd) ^ rxs;
                    cnt_d      = BitLoad;
                    stop_idx_d = 1'b0;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (expired) begin
                    frame_now = frame_q | ~rxs;
                    frame_d   = frame_now;
                    // Leave at the mid-point of the last stop bit for early resync.
                    if (stop_idx_q == 1'(SW - 1)) begin
                        state_d  = IDLE;
                        complete = 1'b1;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                        cnt_d      = BitLoad;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (tvalid_q && str_rxd_tready) begin
            tvalid_d = 1'b0;
        end

        // An accept in the completion cycle frees the slot, so no overrun then.
        if (complete) begin
            if (frame_now) begin
                err_frame_d = 1'b1;
            end else if (tvalid_q && !str_rxd_tready) begin
                err_fifo_d = 1'b1;
            end else begin
                tdata_d   = shreg_q;
                tvalid_d  = 1'b1;
                err_par_d = par_err_q;
            end
        end
    end

    assign str_rxd_tvalid = tvalid_q;
    assign str_rxd_tdata  = tdata_q;
    assign error_fifo     = err_fifo_q;
    assign error_parity   = err_par_q;
    assign error_frame    = err_frame_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int BN = 54;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd_a = 1'b1;
    logic       rxd_b = 1'b1;
    logic       tready_a = 1'b1;
    logic       tready_b = 1'b1;
    logic       tvalid_a, tvalid_b;
    logic [7:0] tdata_a, tdata_b;
    logic       efifo_a, epar_a, eframe_a;
    logic       efifo_b, epar_b, eframe_b;

    always #5 clk = ~clk;

    // A: no parity, one stop bit
    uart_rx #(.DW(8), .PT("NONE"), .SW(1), .BN(BN)) dut_a (
        .clk            (clk),
        .rst            (rst),
        .uart_rxd       (rxd_a),
        .str_rxd_tvalid (tvalid_a),
        .str_rxd_tdata  (tdata_a),
        .str_rxd_tready (tready_a),
        .error_fifo     (efifo_a),
        .error_parity   (epar_a),
        .error_frame    (eframe_a)
    );

    // B: even parity, two stop bits
    uart_rx #(.DW(8), .PT("EVEN"), .SW(2), .BN(BN)) dut_b (
        .clk            (clk),
        .rst            (rst),
        .uart_rxd       (rxd_b),
        .str_rxd_tvalid (tvalid_b),
        .str_rxd_tdata  (tdata_b),
        .str_rxd_tready (tready_b),
        .error_fifo     (efifo_b),
        .error_parity   (epar_b),
        .error_frame    (eframe_b)
    );

    int checks = 0;
    int errors = 0;

    // Output monitor: counts sampled away from the active edge.
    int rises_a = 0, vcyc_a = 0, nfifo_a = 0, npar_a = 0, nframe_a = 0;
    int rises_b = 0, npar_b = 0, npar_rise_b = 0, nother_b = 0;
    logic [7:0] last_a = '0, last_b = '0;
    logic prev_va = 1'b0, prev_vb = 1'b0;

    always @(negedge clk) begin
        if (tvalid_a && !prev_va) begin
            rises_a++;
            last_a = tdata_a;
        end
        if (tvalid_a) vcyc_a++;
        if (efifo_a) nfifo_a++;
        if (epar_a) npar_a++;
        if (eframe_a) nframe_a++;
        prev_va = tvalid_a;
        if (tvalid_b && !prev_vb) begin
            rises_b++;
            last_b = tdata_b;
            if (epar_b) npar_rise_b++;
        end
        if (epar_b) npar_b++;
        if (efifo_b || eframe_b) nother_b++;
        prev_vb = tvalid_b;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rxd_b = v;
        else rxd_a = v;
    endtask

    task automatic hold_bit(input bit sel, input logic v, input bit glitch);
        drive(sel, v);
        if (glitch) begin
            repeat (BN / 2) @(negedge clk);
            drive(sel, ~v);
            @(negedge clk);
            drive(sel, v);
            repeat (BN - BN / 2 - 1) @(negedge clk);
        end else begin
            repeat (BN) @(negedge clk);
        end
    endtask

    // glitch_bit < 0 means no glitch
    task automatic send(input bit sel, input logic [7:0] b, input bit par_en, input logic par_bit,
                        input int nstop, input logic stop_val, input int glitch_bit);
        hold_bit(sel, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) hold_bit(sel, b[i], glitch_bit == i);
        if (par_en) hold_bit(sel, par_bit, 1'b0);
        for (int i = 0; i < nstop; i++) hold_bit(sel, stop_val, 1'b0);
        drive(sel, 1'b1);
    endtask

    int r0, f0, p0, e0;
    logic [7:0] ff_byte;

    initial begin
        repeat (5) @(negedge clk);
        check("reset tvalid", 32'(tvalid_a), 32'd0);
        check("reset tdata", 32'(tdata_a), 32'd0);
        check("reset errors", {29'd0, efifo_a, epar_a, eframe_a}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 1: plain byte
        send(1'b0, 8'hA5, 1'b0, 1'b0, 1, 1'b1, -1);
        repeat (5) @(negedge clk);
        check("t1 rises", rises_a, 1);
        check("t1 data", 32'(last_a), 32'hA5);
        check("t1 valid cycles", vcyc_a, 1);
        check("t1 errors", nfifo_a + npar_a + nframe_a, 0);

        // 2: even parity, wrong bit then correct bit
        send(1'b1, 8'h03, 1'b1, 1'b1, 2, 1'b1, -1);
        repeat (5) @(negedge clk);
        check("t2 rises", rises_b, 1);
        check("t2 data", 32'(last_b), 32'h03);
        check("t2 parity at rise", npar_rise_b, 1);
        check("t2 parity pulses", npar_b, 1);
        send(1'b1, 8'h03, 1'b1, 1'b0, 2, 1'b1, -1);
        repeat (5) @(negedge clk);
        check("t2 good rises", rises_b, 2);
        check("t2 good parity pulses", npar_b, 1);
        check("t2 other errors", nother_b, 0);

        // 3: low stop bit, then recovery
        send(1'b0, 8'h5A, 1'b0, 1'b0, 1, 1'b0, -1);
        repeat (5) @(negedge clk);
        check("t3 frame pulses", nframe_a, 1);
        check("t3 rises", rises_a, 1);
        repeat (BN) @(negedge clk);
        send(1'b0, 8'h11, 1'b0, 1'b0, 1, 1'b1, -1);
        repeat (5) @(negedge clk);
        check("t3 recover rises", rises_a, 2);
        check("t3 recover data", 32'(last_a), 32'h11);

        // 4: overrun while output is held
        tready_a = 1'b0;
        send(1'b0, 8'h11, 1'b0, 1'b0, 1, 1'b1, -1);
        send(1'b0, 8'h22, 1'b0, 1'b0, 1, 1'b1, -1);
        repeat (5) @(negedge clk);
        check("t4 held data", 32'(tdata_a), 32'h11);
        check("t4 held valid", 32'(tvalid_a), 32'd1);
        check("t4 fifo pulses", nfifo_a, 1);
        check("t4 rises", rises_a, 3);
        tready_a = 1'b1;
        @(negedge clk);
        check("t4 accepted", 32'(tvalid_a), 32'd0);

        // 5: short low pulse on idle line
        rxd_a = 1'b0;
        repeat (10) @(negedge clk);
        rxd_a = 1'b1;
        repeat (3 * BN) @(negedge clk);
        check("t5 rises", rises_a, 3);
        check("t5 errors", nfifo_a + npar_a + nframe_a, 2);
`ifdef UART_RX_FILTER_EN
        send(1'b0, 8'hC3, 1'b0, 1'b0, 1, 1'b1, 0);
        repeat (5) @(negedge clk);
        check("t5 glitch rises", rises_a, 4);
        check("t5 glitch data", 32'(last_a), 32'hC3);
`endif

        // 6: reset in the middle of a character
        r0 = rises_a;
        f0 = nframe_a;
        p0 = npar_a;
        e0 = nfifo_a;
        ff_byte = 8'hFF;
        hold_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) hold_bit(1'b0, ff_byte[i], 1'b0);
        repeat (BN / 2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (2 * BN) @(negedge clk);
        check("t6 no valid after reset", 32'(tvalid_a), 32'd0);
        send(1'b0, 8'h81, 1'b0, 1'b0, 1, 1'b1, -1);
        repeat (5) @(negedge clk);
        check("t6 rises", rises_a, r0 + 1);
        check("t6 data", 32'(last_a), 32'h81);
        check("t6 errors", (nframe_a - f0) + (npar_a - p0) + (nfifo_a - e0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
